// File: rtl/wb_regfile_writeback_if.sv
// MEM/WB -> write-back bus: write-back sources and destination in, ID read ports
// and forwarding/debug observation out.
interface wb_regfile_writeback_if;
  logic        WB_RegWrite;
  logic [1:0]  WB_MemToReg;
  logic        WB_halfbyte;
  logic [31:0] WB_Read;
  logic [31:0] WB_ALUResult;
  logic [31:0] WB_PCAddResult;
  logic [4:0]  WB_RegDst;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [31:0] WriteData;
  logic [4:0]  DbgLastDst;
  logic [31:0] DbgLastData;
  logic [15:0] WriteCount;

  modport master (
    output WB_RegWrite, WB_MemToReg, WB_halfbyte, WB_Read, WB_ALUResult,
           WB_PCAddResult, WB_RegDst, ReadReg1, ReadReg2,
    input  ReadData1, ReadData2, WriteData, DbgLastDst, DbgLastData, WriteCount
  );

  modport slave (
    input  WB_RegWrite, WB_MemToReg, WB_halfbyte, WB_Read, WB_ALUResult,
           WB_PCAddResult, WB_RegDst, ReadReg1, ReadReg2,
    output ReadData1, ReadData2, WriteData, DbgLastDst, DbgLastData, WriteCount
  );
endinterface

// File: rtl/wb_regfile_writeback.sv
// Write-back source select plus the 32x32 architectural register file.
// Optional macro WB_BYPASS_EN: same-cycle write-to-read bypass on both read ports.
module wb_regfile_writeback (
  input logic                   Clk,
  input logic                   Reset,
  wb_regfile_writeback_if.slave bus
);

  logic [31:0] regs_q [32];
  logic [31:0] writeData;
  logic        commit;
  logic [4:0]  lastDst_q, lastDst_d;
  logic [31:0] lastData_q, lastData_d;
  logic [15:0] writeCount_q, writeCount_d;
  logic [31:0] readData1, readData2;

  always_comb begin
    writeData = bus.WB_ALUResult;
    case (bus.WB_MemToReg)
      2'b01:   writeData = bus.WB_halfbyte ? {{16{bus.WB_Read[15]}}, bus.WB_Read[15:0]}
                                           : bus.WB_Read;
      2'b10:   writeData = bus.WB_PCAddResult;
      default: writeData = bus.WB_ALUResult;
    endcase
  end

  // Register 0 is hardwired, so writes to it neither commit nor count.
  assign commit = bus.WB_RegWrite && (bus.WB_RegDst != 5'd0) && !Reset;

  always_comb begin
    lastDst_d    = lastDst_q;
    lastData_d   = lastData_q;
    writeCount_d = writeCount_q;
    if (commit) begin
      lastDst_d    = bus.WB_RegDst;
      lastData_d   = writeData;
      writeCount_d = writeCount_q + 16'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      lastDst_q    <= '0;
      lastData_q   <= '0;
      writeCount_q <= '0;
    end else begin
      if (commit) regs_q[bus.WB_RegDst] <= writeData;
      lastDst_q    <= lastDst_d;
      lastData_q   <= lastData_d;
      writeCount_q <= writeCount_d;
    end
  end

  always_comb begin
    readData1 = (bus.ReadReg1 == 5'd0) ? 32'd0 : regs_q[bus.ReadReg1];
    readData2 = (bus.ReadReg2 == 5'd0) ? 32'd0 : regs_q[bus.ReadReg2];
`ifdef WB_BYPASS_EN
    // commit already excludes register 0, so r0 can never be bypassed.
    if (commit && (bus.ReadReg1 == bus.WB_RegDst)) readData1 = writeData;
    if (commit && (bus.ReadReg2 == bus.WB_RegDst)) readData2 = writeData;
`endif
  end

  assign bus.ReadData1   = readData1;
  assign bus.ReadData2   = readData2;
  assign bus.WriteData   = writeData;
  assign bus.DbgLastDst  = lastDst_q;
  assign bus.DbgLastData = lastData_q;
  assign bus.WriteCount  = writeCount_q;

endmodule

// File: tb/tb_wb_regfile_writeback.sv
// Scoreboard bench for wb_regfile_writeback: stimulus queues expected values per
// cycle, a negedge monitor pops and compares them.
module tb_wb_regfile_writeback;

  localparam int SEL_RD1   = 0;
  localparam int SEL_RD2   = 1;
  localparam int SEL_WD    = 2;
  localparam int SEL_DST   = 3;
  localparam int SEL_DATA  = 4;
  localparam int SEL_COUNT = 5;

  typedef struct {
    int          cycle;
    int          sel;
    logic [31:0] exp;
    string       name;
  } checkT;

  logic  Clk;
  logic  Reset;
  int    cycleCnt;
  int    assertCount;
  int    failCount;
  checkT sbQueue[$];

  wb_regfile_writeback_if bus ();

  wb_regfile_writeback dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial cycleCnt = 0;
  always @(posedge Clk) cycleCnt <= cycleCnt + 1;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rw, input logic [1:0] mtr, input logic hb,
                               input logic [31:0] rd, input logic [31:0] alu,
                               input logic [31:0] pc, input logic [4:0] dst,
                               input logic [4:0] rr1, input logic [4:0] rr2);
    bus.WB_RegWrite    = rw;
    bus.WB_MemToReg    = mtr;
    bus.WB_halfbyte    = hb;
    bus.WB_Read        = rd;
    bus.WB_ALUResult   = alu;
    bus.WB_PCAddResult = pc;
    bus.WB_RegDst      = dst;
    bus.ReadReg1       = rr1;
    bus.ReadReg2       = rr2;
  endtask

  task automatic expectNow(input int sel, input logic [31:0] val, input string name);
    checkT c;
    c.cycle = cycleCnt;
    c.sel   = sel;
    c.exp   = val;
    c.name  = name;
    sbQueue.push_back(c);
  endtask

  task automatic checkOutput(input checkT c);
    logic [31:0] act;
    case (c.sel)
      SEL_RD1:   act = bus.ReadData1;
      SEL_RD2:   act = bus.ReadData2;
      SEL_WD:    act = bus.WriteData;
      SEL_DST:   act = {27'd0, bus.DbgLastDst};
      SEL_DATA:  act = bus.DbgLastData;
      default:   act = {16'd0, bus.WriteCount};
    endcase
    assertCount++;
    if (act !== c.exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", c.name, act, c.exp, c.cycle);
    end
  endtask

  // Monitor: every expectation queued for the current cycle is checked mid-cycle.
  always @(negedge Clk) begin
    while (sbQueue.size() > 0 && sbQueue[0].cycle <= cycleCnt) begin
      checkOutput(sbQueue.pop_front());
    end
  end

  initial begin
    assertCount = 0;
    failCount   = 0;

    Reset = 1'b1;
    applyStimulus(1'b1, 2'b00, 1'b0, 32'd0, 32'h0000_00FF, 32'd0, 5'd3, 5'd0, 5'd0);
    tick();
    tick();
    Reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'(i), 5'(i + 16));
      expectNow(SEL_RD1, 32'd0, $sformatf("resetReg%0d", i));
      expectNow(SEL_RD2, 32'd0, $sformatf("resetReg%0d", i + 16));
      tick();
    end
    expectNow(SEL_COUNT, 32'd0, "resetCount");
    expectNow(SEL_DST, 32'd0, "resetDbgDst");
    expectNow(SEL_DATA, 32'd0, "resetDbgData");
    tick();

    applyStimulus(1'b1, 2'b00, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 32'h44, 5'd5, 5'd0, 5'd0);
    expectNow(SEL_WD, 32'h1234_5678, "wdAlu");
    tick();
    applyStimulus(1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd0);
    expectNow(SEL_RD1, 32'h1234_5678, "readReg5");
    expectNow(SEL_DST, 32'd5, "dbgDst5");
    expectNow(SEL_DATA, 32'h1234_5678, "dbgData5");
    expectNow(SEL_COUNT, 32'd1, "count1");
    tick();

    applyStimulus(1'b1, 2'b01, 1'b1, 32'h0000_8001, 32'h1, 32'h2, 5'd9, 5'd0, 5'd0);
    expectNow(SEL_WD, 32'hFFFF_8001, "wdHalfSext");
    tick();
    applyStimulus(1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd9);
    expectNow(SEL_RD2, 32'hFFFF_8001, "readReg9Half");
    tick();
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h0000_8001, 32'h1, 32'h2, 5'd9, 5'd0, 5'd0);
    expectNow(SEL_WD, 32'h0000_8001, "wdWord");
    tick();
    applyStimulus(1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd9, 5'd0);
    expectNow(SEL_RD1, 32'h0000_8001, "readReg9Word");
    expectNow(SEL_COUNT, 32'd3, "count3");
    tick();

    applyStimulus(1'b1, 2'b10, 1'b0, 32'd0, 32'h55, 32'h40, 5'd0, 5'd0, 5'd0);
    expectNow(SEL_WD, 32'h40, "wdPc");
    tick();
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h77, 32'hA5A5, 32'h40, 5'd0, 5'd0, 5'd0);
    expectNow(SEL_WD, 32'hA5A5, "wdReserved");
    expectNow(SEL_RD1, 32'd0, "reg0AfterWrite");
    expectNow(SEL_COUNT, 32'd3, "countAfterR0");
    expectNow(SEL_DST, 32'd9, "dbgDstAfterR0");
    tick();

`ifdef WB_BYPASS_EN
    applyStimulus(1'b1, 2'b00, 1'b0, 32'd0, 32'hCAFE_F00D, 32'd0, 5'd7, 5'd7, 5'd7);
    expectNow(SEL_RD1, 32'hCAFE_F00D, "bypassRd1");
    expectNow(SEL_RD2, 32'hCAFE_F00D, "bypassRd2");
`else
    applyStimulus(1'b1, 2'b00, 1'b0, 32'd0, 32'hCAFE_F00D, 32'd0, 5'd7, 5'd7, 5'd7);
    expectNow(SEL_RD1, 32'd0, "noBypassRd1");
    expectNow(SEL_RD2, 32'd0, "noBypassRd2");
`endif
    tick();
    // A non-committing write to the same register must not leak onto the read ports.
    applyStimulus(1'b0, 2'b00, 1'b0, 32'd0, 32'h1111_1111, 32'd0, 5'd7, 5'd7, 5'd7);
    expectNow(SEL_RD1, 32'hCAFE_F00D, "reg7Rd1");
    expectNow(SEL_RD2, 32'hCAFE_F00D, "reg7Rd2");
    expectNow(SEL_COUNT, 32'd4, "count4");
    tick();

    Reset = 1'b1;
    applyStimulus(1'b1, 2'b00, 1'b0, 32'd0, 32'h0000_00FF, 32'd0, 5'd3, 5'd0, 5'd0);
    tick();
    Reset = 1'b0;
    applyStimulus(1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd3, 5'd7);
    expectNow(SEL_RD1, 32'd0, "reg3AfterReset");
    expectNow(SEL_RD2, 32'd0, "reg7AfterReset");
    expectNow(SEL_COUNT, 32'd0, "countAfterReset");
    expectNow(SEL_DST, 32'd0, "dbgDstAfterReset");
    tick();

    for (int i = 0; i < 65535; i++) begin
      applyStimulus(1'b1, 2'b00, 1'b0, 32'd0, 32'(i), 32'd0, 5'd1, 5'd0, 5'd0);
      tick();
    end
    applyStimulus(1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd1, 5'd0);
    expectNow(SEL_COUNT, 32'h0000_FFFF, "countFFFF");
    expectNow(SEL_RD1, 32'd65534, "reg1BeforeWrap");
    tick();
    applyStimulus(1'b1, 2'b00, 1'b0, 32'd0, 32'h0BAD_CAFE, 32'd0, 5'd1, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd1, 5'd0);
    expectNow(SEL_COUNT, 32'd0, "countWrap");
    expectNow(SEL_DATA, 32'h0BAD_CAFE, "dbgDataWrap");
    expectNow(SEL_RD1, 32'h0BAD_CAFE, "reg1AfterWrap");
    tick();

    for (int i = 0; i < 10 && sbQueue.size() > 0; i++) tick();
    if (sbQueue.size() > 0) begin
      failCount++;
      $display("[TB] FAIL scoreboardDrain: got %0d pending, expected 0", sbQueue.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
